// File: rtl/ir_key_event.sv
// NEC frame validator and key event generator (press pulse, held level, buttons, mute).
// Optional custom-code check is compiled in with `define IR_CUSTOM_CHECK_EN.
module ir_key_event #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned HOLD_TIMEOUT_MS = 120,
    parameter logic [15:0] CUSTOM_CODE     = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [31:0] ir_data,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_held,
    output logic [3:0]  button,
    output logic        mute,
    output logic [7:0]  err_count
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * HOLD_TIMEOUT_MS;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          dr_q, dr_d;
    logic          frame_evt_q, frame_evt_d;
    logic [31:0]   frame_q, frame_d;
    logic          acc_q, acc_d;
    logic          rej_q, rej_d;
    logic [7:0]    cand_q, cand_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;
    logic [3:0]    button_q, button_d;
    logic          mute_q, mute_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          custom_ok;
    logic          frame_ok;
    logic          new_press;

`ifdef IR_CUSTOM_CHECK_EN
    assign custom_ok = (frame_q[15:0] == CUSTOM_CODE);
`else
    logic unused_custom;
    assign custom_ok     = 1'b1;
    assign unused_custom = ^{frame_q[15:0], CUSTOM_CODE};
`endif

    assign frame_ok = (frame_q[31:24] == ~frame_q[23:16]) && custom_ok;

    always_comb begin
        dr_d        = data_ready;
        frame_evt_d = data_ready & ~dr_q;
        frame_d     = frame_evt_d ? ir_data : frame_q;
        acc_d       = frame_evt_q & frame_ok;
        rej_d       = frame_evt_q & ~frame_ok;
        cand_d      = frame_q[23:16];

        state_d     = state_q;
        timer_d     = timer_q;
        key_valid_d = 1'b0;
        button_d    = '0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        mute_d      = mute_q;
        err_count_d = (rej_q && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
        new_press   = 1'b0;

        case (state_q)
            IDLE: new_press = acc_q;
            PRESSED, HELD: begin
                if (acc_q) begin
                    if (cand_q == key_code_q) begin
                        key_held_d = 1'b1;
                        state_d    = HELD;
                        timer_d    = TW'(TIMEOUT_CYC);
                    end else begin
                        new_press = 1'b1;
                    end
                // Expiry is taken as the count reaches zero, so the press ends
                // exactly TIMEOUT_CYC cycles after the last accepted frame.
                end else if (timer_q > TW'(1)) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    timer_d    = '0;
                    key_held_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_press) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_q;
            key_held_d  = 1'b0;
            state_d     = PRESSED;
            timer_d     = TW'(TIMEOUT_CYC);
            for (int unsigned i = 0; i < 4; i++) begin
                button_d[i] = (cand_q == 8'(i + 1));
            end
            if (cand_q == 8'h0C) begin
                mute_d = ~mute_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            dr_q        <= 1'b0;
            frame_evt_q <= 1'b0;
            frame_q     <= '0;
            acc_q       <= 1'b0;
            rej_q       <= 1'b0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            button_q    <= '0;
            mute_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dr_q        <= dr_d;
            frame_evt_q <= frame_evt_d;
            frame_q     <= frame_d;
            acc_q       <= acc_d;
            rej_q       <= rej_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            button_q    <= button_d;
            mute_q      <= mute_d;
            err_count_q <= err_count_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign button    = button_q;
    assign mute      = mute_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ir_key_event.sv
// Directed bench for ir_key_event: a scoreboard holds the expected state of each
// key_valid pulse; level outputs are checked at fixed points after each frame.
module tb_ir_key_event;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_ready;
    logic [31:0] ir_data;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_held;
    logic [3:0]  button;
    logic        mute;
    logic [7:0]  err_count;

    int total = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] btn;
        logic       mute;
        logic       held;
    } exp_t;

    exp_t sb_q[$];

    ir_key_event #(
        .CLK_HZ          (1000),
        .HOLD_TIMEOUT_MS (10),
        .CUSTOM_CODE     (16'h6B86)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_ready (data_ready),
        .ir_data    (ir_data),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_held   (key_held),
        .button     (button),
        .mute       (mute),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Every key_valid pulse must match the next expected press.
    always @(negedge clk) begin
        if (!reset && key_valid === 1'b1) begin
            total++;
            assert (sb_q.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected: key_valid observed code=%h, expected no press", key_code);
            end
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                total++;
                assert ({key_code, button, mute, key_held} === e) else begin
                    fails++;
                    $error("FAIL sb_press: observed code=%h btn=%b mute=%b held=%b expected code=%h btn=%b mute=%b held=%b",
                           key_code, button, mute, key_held, e.code, e.btn, e.mute, e.held);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle data_ready pulse; returns just after the E+2 edge.
    task automatic frame(input logic [31:0] f);
        @(negedge clk);
        ir_data    = f;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        tick(2);
    endtask

    task automatic push(input logic [7:0] c, input logic [3:0] b, input logic m);
        sb_q.push_back({c, b, m, 1'b0});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_kv"},   32'(key_valid), 32'd0);
        check({tag, "_code"}, 32'(key_code),  32'd0);
        check({tag, "_held"}, 32'(key_held),  32'd0);
        check({tag, "_btn"},  32'(button),    32'd0);
        check({tag, "_mute"}, 32'(mute),      32'd0);
        check({tag, "_err"},  32'(err_count), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        data_ready = 1'b0;
        ir_data    = '0;
        tick(3);
        reset = 1'b0;
        check_reset("rst0");

        // Press and hold
        push(8'h01, 4'b0001, 1'b0);
        frame(32'hFE01_0000);
        check("press_kv", 32'(key_valid), 32'd1);
        check("press_held", 32'(key_held), 32'd0);
        tick(1);
        check("press_kv_low", 32'(key_valid), 32'd0);
        check("press_btn_low", 32'(button), 32'd0);
        tick(3);
        frame(32'hFE01_0000);
        check("hold2_held", 32'(key_held), 32'd1);
        check("hold2_code", 32'(key_code), 32'h01);
        tick(4);
        frame(32'hFE01_0000);
        tick(4);
        frame(32'hFE01_0000);
        check("hold4_held", 32'(key_held), 32'd1);
        tick(9);
        check("hold_pre_timeout", 32'(key_held), 32'd1);
        tick(1);
        check("hold_timeout", 32'(key_held), 32'd0);

        // Mute toggling
        push(8'h0C, 4'b0000, 1'b1);
        frame(32'hF30C_0000);
        check("mute_on", 32'(mute), 32'd1);
        tick(2);
        frame(32'hF30C_0000);
        check("mute_repeat", 32'(mute), 32'd1);
        check("mute_repeat_held", 32'(key_held), 32'd1);
        tick(15);
        push(8'h0C, 4'b0000, 1'b0);
        frame(32'hF30C_0000);
        check("mute_off", 32'(mute), 32'd0);
        tick(15);

        // Key change inside the hold window
        push(8'h01, 4'b0001, 1'b0);
        frame(32'hFE01_0000);
        tick(1);
        push(8'h02, 4'b0010, 1'b0);
        frame(32'hFD02_0000);
        check("change_code", 32'(key_code), 32'h02);
        check("change_held", 32'(key_held), 32'd0);
        tick(15);

        // Rejects and saturation
        frame(32'hFE02_0000);
        check("rej_err1", 32'(err_count), 32'd1);
        check("rej_code_kept", 32'(key_code), 32'h02);
        for (int i = 0; i < 300; i++) begin
            frame(32'hFE02_0000);
        end
        check("rej_sat", 32'(err_count), 32'd255);
        push(8'h03, 4'b0100, 1'b0);
        frame(32'hFC03_0000);
        check("good_after_sat_code", 32'(key_code), 32'h03);
        check("good_after_sat_err", 32'(err_count), 32'd255);
        tick(15);

        // Mid-run reset clears saturated counter
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset("rst1");

        push(8'h0C, 4'b0000, 1'b1);
        frame(32'hF30C_6B86);
        tick(15);

        // Custom code check and reset while held
`ifdef IR_CUSTOM_CHECK_EN
        frame(32'hFE01_0000);
        check("cust_rej_err", 32'(err_count), 32'd1);
        push(8'h01, 4'b0001, 1'b1);
        frame(32'hFE01_6B86);
        check("cust_acc_code", 32'(key_code), 32'h01);
        tick(2);
        frame(32'hFE01_6B86);
`else
        push(8'h01, 4'b0001, 1'b1);
        frame(32'hFE01_0000);
        check("cust_ignored_err", 32'(err_count), 32'd0);
        check("cust_ignored_code", 32'(key_code), 32'h01);
        tick(2);
        frame(32'hFE01_6B86);
`endif
        check("pre_reset_held", 32'(key_held), 32'd1);
        check("pre_reset_mute", 32'(mute), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rst_held");
        reset = 1'b0;
        tick(20);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/ir_key_event.md
# ir_key_event

Downstream consumer of the IR receiver's decoded 32-bit NEC frame and data-ready flag. Validates each frame and turns the frame stream into clean key events: one press pulse per physical press, a held indication while the remote sends repeats, one-hot button pulses, and a mute toggle. It sits between the IR receive path and the top-level control logic, replacing ad-hoc `hex_data` compares at top level.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, frequency of `clk` in Hz.
- `HOLD_TIMEOUT_MS`, 120, time without an accepted frame after which a press ends. The NEC repeat period is 108 ms.
- `CUSTOM_CODE`, 16'h0000, expected custom code in `ir_data[15:0]`. Used only when `IR_CUSTOM_CHECK_EN` is defined.

Ports:
- `clk` in 1: the single clock, same domain as the IR receiver outputs.
- `reset` in 1: reset is synchronous and active-high.
- `data_ready` in 1: frame-available level from the IR receiver. A new frame is its rising edge.
- `ir_data` in 32: decoded frame. [31:24] = ~key, [23:16] = key, [15:0] = custom code.
- `key_valid` out 1: one-cycle pulse on a new press.
- `key_code` out 8: key of the last press. Holds its value between presses.
- `key_held` out 1: level, high while repeats of the current key continue.
- `button` out 4: one-cycle one-hot pulse, coincident with `key_valid`, for keys 0x01..0x04 (bit0 = 0x01).
- `mute` out 1: level that toggles on each new press of key 0x0C.
- `err_count` out 8: saturating count of rejected frames.

## Operation
- Edge detect: register `dr_q <= data_ready`. A frame event occurs when `data_ready & ~dr_q`. On that edge, `ir_data` is captured into `frame_q`, and `frame_evt_q` is set for one cycle.
- Validation (on `frame_evt_q`): the frame is accepted iff `frame_q[31:24] == ~frame_q[23:16]`, plus the custom check when it is compiled in. Let k = `frame_q[23:16]`.
- Rejected frame: `err_count` increments, saturating at 255. State, timer and all other outputs are unchanged.
- Hold timer: a down-counter loaded with `TIMEOUT_CYC = CLK_HZ/1000*HOLD_TIMEOUT_MS`. Its width is `$clog2(TIMEOUT_CYC+1)`. It decrements to 0 in PRESSED/HELD and is reloaded on every accepted frame.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE + accept: pulse `key_valid`, set `key_code`=k, load timer, go to PRESSED.
  - PRESSED + accept with k == `key_code`: `key_held`=1, reload timer, go to HELD.
  - PRESSED/HELD + accept with k != `key_code`: pulse `key_valid`, set `key_code`=k, `key_held`=0, reload timer, go to PRESSED.
  - HELD + accept with same k: reload timer, stay in HELD.
  - PRESSED/HELD + timer == 0 with no accept: `key_held`=0, go to IDLE.
- `button[i]` pulses with `key_valid` when k == i+1. Otherwise it is 0.
- `mute` toggles only on a `key_valid` with k == 0x0C. It never toggles on repeats.

## Timing
- Reset values: `key_valid`=0, `key_code`=8'h00, `key_held`=0, `button`=4'b0000, `mute`=0, `err_count`=8'h00. The FSM is in IDLE, timer=0, `dr_q`=0, `frame_q`=0.
- Latency: if `data_ready` is first sampled high at edge E, then `key_valid`/`button`/`mute`/`key_code`/`key_held`/`err_count` update at edge E+2. `key_valid` is high for exactly one cycle.
- `data_ready` held high for many cycles counts as one frame. A new frame needs `data_ready` to go low for at least one sampled cycle.
- If an accept and timer==0 occur in the same cycle, the accept wins and is processed per the current state.
- `reset` asserted mid-operation returns all state and outputs to reset values on that edge, including `mute` and `err_count`.
- `data_ready` rising in the same cycle that `reset` is asserted is ignored.

## Configuration
- `IR_CUSTOM_CHECK_EN` defined: a frame is also rejected when `frame_q[15:0] != CUSTOM_CODE`. Such a frame counts in `err_count` like a complement mismatch.
- `IR_CUSTOM_CHECK_EN` undefined: `ir_data[15:0]` is ignored and `CUSTOM_CODE` has no effect.

## Test plan
Benches use `CLK_HZ`=1000 and `HOLD_TIMEOUT_MS`=10, so `TIMEOUT_CYC`=10.
- Press: after reset, drive `ir_data`=32'hFE01_0000 with a `data_ready` pulse. Required: `key_valid` 1 cycle at E+2, `key_code`=8'h01, `button`=4'b0001, `key_held`=0.
- Hold: repeat the same frame every 8 cycles, 3 times. Required: exactly one `key_valid`; `key_held`=1 from the 2nd frame; `key_held` drops and the FSM reaches IDLE 10 cycles after the last frame's E+2.
- Mute: send frame 32'hF30C_0000, wait more than 10 cycles, send it again. Required: `mute` goes 0→1→0. A repeat inside the timeout leaves `mute` unchanged.
- Key change: send 32'hFE01_0000, then 32'hFD02_0000 within 5 cycles. Required: two `key_valid` pulses, the second with `button`=4'b0010 and `key_held`=0.
- Reject/saturate: send 32'hFE02_0000. Required: no `key_valid`, `err_count`=1. After 300 bad frames, `err_count`=255. A good frame then still pulses `key_valid`.
- Custom and reset: with the macro defined and `CUSTOM_CODE`=16'h6B86, send 32'hFE01_0000. Required: rejected, `err_count`+1. Then send 32'hFE01_6B86. Required: accepted. Assert `reset` while in HELD. Required: all outputs at reset values on the next edge.
